// File: rtl/psum_accum_ctrl_if.sv
// -----------------------------------------------------------------------------
// psum_accum_ctrl_if
//   Bundles every non-clock/reset signal of the partial-sum accumulation
//   controller: job start/config, partial-sum input stream, final-sum output
//   stream, status, and the register-file write/read port.
//   master : the controller side (drives o_* signals)
//   slave  : the surroundings (PE column, output buffer, RF, sequencer)
// -----------------------------------------------------------------------------
interface psum_accum_ctrl_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int PASS_WIDTH = 4
);
  logic                  i_start;
  logic [ADDR_WIDTH-1:0] i_cfg_last_addr;
  logic [PASS_WIDTH-1:0] i_cfg_last_pass;
  logic                  i_in_valid;
  logic [DATA_WIDTH-1:0] i_in_data;
  logic                  o_in_ready;
  logic                  o_out_valid;
  logic [DATA_WIDTH-1:0] o_out_data;
  logic                  i_out_ready;
  logic                  o_busy;
  logic                  o_done;
  logic                  o_rf_wr_en;
  logic [ADDR_WIDTH-1:0] o_rf_wr_addr;
  logic [DATA_WIDTH-1:0] o_rf_wr_data;
  logic [ADDR_WIDTH-1:0] o_rf_rd_addr;
  logic [DATA_WIDTH-1:0] i_rf_rd_data;

  modport master (
    input  i_start, i_cfg_last_addr, i_cfg_last_pass, i_in_valid, i_in_data,
           i_out_ready, i_rf_rd_data,
    output o_in_ready, o_out_valid, o_out_data, o_busy, o_done,
           o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_rf_rd_addr
  );

  modport slave (
    output i_start, i_cfg_last_addr, i_cfg_last_pass, i_in_valid, i_in_data,
           i_out_ready, i_rf_rd_data,
    input  o_in_ready, o_out_valid, o_out_data, o_busy, o_done,
           o_rf_wr_en, o_rf_wr_addr, o_rf_wr_data, o_rf_rd_addr
  );
endinterface

// File: rtl/psum_accum_ctrl.sv
// -----------------------------------------------------------------------------
// psum_accum_ctrl
//   Owns one column partial-sum register file (combinational read, synchronous
//   write). A job accumulates (last_pass+1) passes of (last_addr+1) partial
//   sums into RF entries 0..last_addr, then drains the final sums through a
//   valid/ready port and pulses o_done for one cycle.
// Ports
//   i_clk, i_rst : clock, synchronous active-high reset
//   bus (master) : start/cfg, input stream (valid/ready), output stream
//                  (valid/ready), busy/done status, RF write port and RF
//                  read address/data.
// -----------------------------------------------------------------------------
module psum_accum_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 5,
  parameter int PASS_WIDTH = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  psum_accum_ctrl_if.master  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [PASS_WIDTH-1:0] pass_q, pass_d;
  logic [ADDR_WIDTH-1:0] last_addr_q, last_addr_d;
  logic [PASS_WIDTH-1:0] last_pass_q, last_pass_d;
  logic                  done_q, done_d;

  logic                  run;
  logic                  accept;
  logic                  xfer;

  // Accumulation wraps modulo 2^DATA_WIDTH; no saturation.
  function automatic logic [DATA_WIDTH-1:0] acc_wrap(
    input logic [DATA_WIDTH-1:0] a,
    input logic [DATA_WIDTH-1:0] b
  );
    logic [DATA_WIDTH-1:0] s;
    s = a + b;
    return s;
  endfunction

  // While reset is asserted every handshake/write output is forced low,
  // even though the state register only clears at the next edge.
  assign run    = ~i_rst;
  assign accept = (state_q == S_ACCUM) && bus.i_in_valid;
  assign xfer   = (state_q == S_DRAIN) && bus.i_out_ready;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pass_d      = pass_q;
    last_addr_d = last_addr_q;
    last_pass_d = last_pass_q;
    done_d      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.i_start) begin
          last_addr_d = bus.i_cfg_last_addr;
          last_pass_d = bus.i_cfg_last_pass;
          addr_d      = '0;
          pass_d      = '0;
          state_d     = S_ACCUM;
        end
      end
      S_ACCUM: begin
        if (accept) begin
          if (addr_q == last_addr_q) begin
            addr_d = '0;
            pass_d = pass_q + 1'b1;
            if (pass_q == last_pass_q) begin
              state_d = S_DRAIN;
            end
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (xfer) begin
          if (addr_q == last_addr_q) begin
            addr_d  = '0;
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Control state: reset to a clean idle controller.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      pass_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

  // Job configuration: only meaningful after a start, so no reset needed.
  always_ff @(posedge i_clk) begin
    last_addr_q <= last_addr_d;
    last_pass_q <= last_pass_d;
  end

  // Pass 0 overwrites so stale RF contents from an earlier or aborted job
  // never leak into a new result. Later passes read-modify-write in one cycle.
  always_comb begin
    bus.o_in_ready   = run && (state_q == S_ACCUM);
    bus.o_busy       = run && (state_q != S_IDLE);
    bus.o_out_valid  = run && (state_q == S_DRAIN);
    bus.o_out_data   = bus.o_out_valid ? bus.i_rf_rd_data : '0;
    bus.o_done       = run && done_q;
    bus.o_rf_rd_addr = addr_q;
    bus.o_rf_wr_en   = run && accept;
    bus.o_rf_wr_addr = '0;
    bus.o_rf_wr_data = '0;
    if (bus.o_rf_wr_en) begin
      bus.o_rf_wr_addr = addr_q;
      bus.o_rf_wr_data = (pass_q == '0) ? bus.i_in_data
                                        : acc_wrap(bus.i_rf_rd_data, bus.i_in_data);
    end
  end

endmodule
